// File: rtl/exp_op_sequencer_if.sv
// exp_op_sequencer_if: start/done/ack handshake between the FPU controller and the exponent sequencer
interface exp_op_sequencer_if;
  logic       start_i;
  logic [1:0] cmd_i;
  logic       ack_i;
  logic       abort_i;
  logic       busy_o;
  logic       done_o;
  logic       ovf_o;
  logic       unf_o;
  logic       err_o;
  modport master (output start_i, cmd_i, ack_i, abort_i, input busy_o, done_o, ovf_o, unf_o, err_o);
  modport slave (input start_i, cmd_i, ack_i, abort_i, output busy_o, done_o, ovf_o, unf_o, err_o);
endinterface

// File: rtl/exp_op_sequencer.sv
// exp_op_sequencer: drives the exponent add/sub datapath (selects, settle, load); EXP_SEQ_PERF_EN adds op/exception counters
module exp_op_sequencer #(
  parameter int SETTLE = 1,
  parameter int CNTW = 16
) (
  input  logic clk,
  input  logic rst_n,
  exp_op_sequencer_if.slave bus,
  input  logic overflow_flag_i,
  input  logic underflow_flag_i,
  output logic ctrl_a_o,
  output logic fsm_add_subt_o,
  output logic fsm_select_a_o,
  output logic fsm_select_b_o
`ifdef EXP_SEQ_PERF_EN
  ,
  output logic [CNTW-1:0] op_cnt_o,
  output logic [CNTW-1:0] exc_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, SETUP, LOAD, DONE} state_t;
  localparam logic [3:0] SET_M1 = 4'(SETTLE - 1);
  if (SETTLE < 1 || SETTLE > 15 || CNTW < 1) begin : g_bad_param
    $error("exp_op_sequencer: SETTLE must be 1..15 and CNTW >= 1");
  end
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic accept, rsv, load_ok;
  always_comb begin
    rsv = bus.cmd_i == 2'd3;
    accept = bus.start_i && (state == IDLE || (state == DONE && bus.ack_i));
    load_ok = state == LOAD && !bus.abort_i;
    state_n = accept ? (rsv ? DONE : SETUP)
            : ((state == SETUP || state == LOAD) && bus.abort_i) ? IDLE
            : state == SETUP ? (cnt == 4'd0 ? LOAD : SETUP)
            : state == LOAD ? DONE
            : (state == DONE && bus.ack_i) ? IDLE
            : state;
    cnt_n = (accept && !rsv) ? SET_M1
          : (state == SETUP && cnt != 4'd0) ? cnt - 4'd1
          : cnt;
  end
  // every output is registered from the next state so reset clears them all at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      ctrl_a_o <= 1'b0;
      fsm_add_subt_o <= 1'b0;
      fsm_select_a_o <= 1'b0;
      fsm_select_b_o <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.ovf_o <= 1'b0;
      bus.unf_o <= 1'b0;
      bus.err_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ctrl_a_o <= state_n == LOAD;
      bus.busy_o <= state_n != IDLE;
      bus.done_o <= state_n == DONE;
      if (accept) begin
        bus.ovf_o <= 1'b0;
        bus.unf_o <= 1'b0;
        bus.err_o <= rsv;
        if (!rsv) begin
          fsm_select_a_o <= bus.cmd_i != 2'd0;
          fsm_select_b_o <= bus.cmd_i != 2'd0;
          fsm_add_subt_o <= bus.cmd_i != 2'd1;
        end
      end
      if (load_ok) begin
        bus.ovf_o <= overflow_flag_i;
        bus.unf_o <= underflow_flag_i;
      end
    end
  end
`ifdef EXP_SEQ_PERF_EN
  logic entry, exc;
  always_comb begin
    entry = state_n == DONE && (state != DONE || accept);
    exc = load_ok ? (overflow_flag_i || underflow_flag_i) : 1'b1;
  end
  // outside LOAD the only way into DONE is a reserved command, which is always an exception
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_o <= '0;
      exc_cnt_o <= '0;
    end else if (entry) begin
      op_cnt_o <= op_cnt_o + 1'b1;
      if (exc) exc_cnt_o <= exc_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_exp_op_sequencer.sv
// tb_exp_op_sequencer: directed checks of exp_op_sequencer with SETTLE=1 (dut1) and SETTLE=4 (dut4)
module tb_exp_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic ack = 1'b0;
  logic abort = 1'b0;
  logic ovf_in = 1'b0;
  logic unf_in = 1'b0;
  logic ctrl1, add1, sa1, sb1, ctrl4, add4, sa4, sb4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  exp_op_sequencer_if if1 ();
  exp_op_sequencer_if if4 ();
  assign if1.start_i = start;
  assign if1.cmd_i = cmd;
  assign if1.ack_i = ack;
  assign if1.abort_i = abort;
  assign if4.start_i = start;
  assign if4.cmd_i = cmd;
  assign if4.ack_i = ack;
  assign if4.abort_i = abort;
`ifdef EXP_SEQ_PERF_EN
  logic [15:0] op1, exc1, op4, exc4;
`endif
  exp_op_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .overflow_flag_i(ovf_in), .underflow_flag_i(unf_in),
    .ctrl_a_o(ctrl1), .fsm_add_subt_o(add1), .fsm_select_a_o(sa1), .fsm_select_b_o(sb1)
`ifdef EXP_SEQ_PERF_EN
    , .op_cnt_o(op1), .exc_cnt_o(exc1)
`endif
  );
  exp_op_sequencer #(.SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave),
    .overflow_flag_i(ovf_in), .underflow_flag_i(unf_in),
    .ctrl_a_o(ctrl4), .fsm_add_subt_o(add4), .fsm_select_a_o(sa4), .fsm_select_b_o(sb4)
`ifdef EXP_SEQ_PERF_EN
    , .op_cnt_o(op4), .exc_cnt_o(exc4)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    #3;
    checks++; if ({ctrl1, add1, sa1, sb1} !== 4'b0) begin errors++; $display("FAIL reset_dp1 got %b exp 0000", {ctrl1, add1, sa1, sb1}); end
    checks++; if ({if1.busy_o, if1.done_o, if1.ovf_o, if1.unf_o, if1.err_o} !== 5'b0) begin errors++; $display("FAIL reset_bus1 got %b exp 00000", {if1.busy_o, if1.done_o, if1.ovf_o, if1.unf_o, if1.err_o}); end
    checks++; if ({ctrl4, if4.busy_o, if4.done_o} !== 3'b0) begin errors++; $display("FAIL reset_dut4 got %b exp 000", {ctrl4, if4.busy_o, if4.done_o}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_diff();
    start = 1'b1; cmd = 2'd0;
    tick();
    start = 1'b0;
    checks++; if ({sa1, sb1, add1, if1.busy_o, ctrl1, if1.done_o} !== 6'b001100) begin errors++; $display("FAIL diff_accept got %b exp 001100", {sa1, sb1, add1, if1.busy_o, ctrl1, if1.done_o}); end
    tick();
    checks++; if ({ctrl1, if1.done_o} !== 2'b10) begin errors++; $display("FAIL diff_load got %b exp 10", {ctrl1, if1.done_o}); end
    tick();
    checks++; if ({ctrl1, if1.done_o, if1.ovf_o, if1.unf_o, if1.busy_o} !== 5'b01001) begin errors++; $display("FAIL diff_done got %b exp 01001", {ctrl1, if1.done_o, if1.ovf_o, if1.unf_o, if1.busy_o}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if ({if1.done_o, if1.busy_o} !== 2'b00) begin errors++; $display("FAIL diff_ack got %b exp 00", {if1.done_o, if1.busy_o}); end
  endtask
  task automatic test_inc_ovf();
    start = 1'b1; cmd = 2'd1;
    tick();
    start = 1'b0;
    checks++; if ({sa1, sb1, add1} !== 3'b110) begin errors++; $display("FAIL inc_sel got %b exp 110", {sa1, sb1, add1}); end
    tick();
    ovf_in = 1'b1;
    checks++; if (ctrl1 !== 1'b1) begin errors++; $display("FAIL inc_load got %b exp 1", ctrl1); end
    tick();
    ovf_in = 1'b0;
    checks++; if ({if1.done_o, if1.ovf_o, if1.unf_o} !== 3'b110) begin errors++; $display("FAIL inc_done got %b exp 110", {if1.done_o, if1.ovf_o, if1.unf_o}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++; if ({if1.busy_o, if1.ovf_o} !== 2'b01) begin errors++; $display("FAIL inc_ovf_hold got %b exp 01", {if1.busy_o, if1.ovf_o}); end
  endtask
  task automatic test_reserved();
    start = 1'b1; cmd = 2'd3;
    tick();
    start = 1'b0;
    checks++; if ({if1.done_o, if1.err_o, ctrl1, if1.ovf_o} !== 4'b1100) begin errors++; $display("FAIL rsv_done got %b exp 1100", {if1.done_o, if1.err_o, ctrl1, if1.ovf_o}); end
    checks++; if ({sa1, sb1, add1} !== 3'b110) begin errors++; $display("FAIL rsv_sel got %b exp 110", {sa1, sb1, add1}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if ({if1.busy_o, if1.err_o} !== 2'b01) begin errors++; $display("FAIL rsv_ack got %b exp 01", {if1.busy_o, if1.err_o}); end
  endtask
  task automatic test_back_to_back();
    start = 1'b1; cmd = 2'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; cmd = 2'd1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if ({if1.done_o, sa1, add1} !== 3'b101) begin errors++; $display("FAIL b2b_ignore got %b exp 101", {if1.done_o, sa1, add1}); end
    start = 1'b1; ack = 1'b1; cmd = 2'd2;
    tick();
    start = 1'b0; ack = 1'b0;
    checks++; if ({if1.busy_o, if1.done_o, ctrl1, sa1, sb1, add1} !== 6'b100111) begin errors++; $display("FAIL b2b_setup got %b exp 100111", {if1.busy_o, if1.done_o, ctrl1, sa1, sb1, add1}); end
    tick();
    checks++; if ({if1.done_o, ctrl1} !== 2'b01) begin errors++; $display("FAIL b2b_load got %b exp 01", {if1.done_o, ctrl1}); end
    tick();
    checks++; if ({if1.done_o, ctrl1} !== 2'b10) begin errors++; $display("FAIL b2b_done got %b exp 10", {if1.done_o, ctrl1}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask
  task automatic test_abort_load();
    start = 1'b1; cmd = 2'd0;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1; ovf_in = 1'b1;
    tick();
    abort = 1'b0; ovf_in = 1'b0;
    checks++; if ({ctrl1, if1.done_o, if1.busy_o, if1.ovf_o} !== 4'b0000) begin errors++; $display("FAIL abort_load got %b exp 0000", {ctrl1, if1.done_o, if1.busy_o, if1.ovf_o}); end
    tick();
    checks++; if ({ctrl1, if1.done_o} !== 2'b00) begin errors++; $display("FAIL abort_stay got %b exp 00", {ctrl1, if1.done_o}); end
  endtask
  task automatic test_settle4();
    int bad;
    do_reset();
    start = 1'b1; cmd = 2'd2;
    tick();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ctrl4 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL settle4_early got %0d early pulses exp 0", bad); end
    tick();
    checks++; if ({ctrl4, if4.done_o, sa4, add4} !== 4'b1011) begin errors++; $display("FAIL settle4_load got %b exp 1011", {ctrl4, if4.done_o, sa4, add4}); end
    tick();
    checks++; if ({ctrl4, if4.done_o} !== 2'b01) begin errors++; $display("FAIL settle4_done got %b exp 01", {ctrl4, if4.done_o}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    start = 1'b1; cmd = 2'd2;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({if4.busy_o, ctrl4, if4.done_o} !== 3'b000) begin errors++; $display("FAIL settle4_abort got %b exp 000", {if4.busy_o, ctrl4, if4.done_o}); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ctrl4 !== 1'b0 || if4.done_o !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL settle4_after_abort got %0d active cycles exp 0", bad); end
  endtask
  task automatic test_async_reset();
    do_reset();
    start = 1'b1; cmd = 2'd0;
    tick();
    start = 1'b0;
    tick();
    checks++; if (ctrl1 !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", ctrl1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ctrl1, if1.done_o, if1.busy_o} !== 3'b000) begin errors++; $display("FAIL areset_drop got %b exp 000", {ctrl1, if1.done_o, if1.busy_o}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`ifdef EXP_SEQ_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; cmd = 2'(i);
      tick();
      start = 1'b0;
      tick();
      ovf_in = (i == 1);
      tick();
      ovf_in = 1'b0;
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    checks++; if (op1 !== 16'd3) begin errors++; $display("FAIL perf_op got %0d exp 3", op1); end
    checks++; if (exc1 !== 16'd1) begin errors++; $display("FAIL perf_exc got %0d exp 1", exc1); end
  endtask
`endif
  initial begin
    test_reset();
    test_diff();
    test_inc_ovf();
    test_reserved();
    test_back_to_back();
    test_abort_load();
    test_settle4();
    test_async_reset();
`ifdef EXP_SEQ_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exp_op_sequencer.md
Name: exp_op_sequencer

Overview:
FSM that drives the exponent add/subtract datapath of the add/subt FPU. It sets the datapath's operand-mux selects and its add/subtract mode, waits a settle window, then pulses the result-register load. It captures the overflow/underflow flags the datapath produces at load time and reports completion to the top-level FPU controller through a start/done/ack handshake.

Parameters:
SETTLE, 1, number of cycles the selects are held before the load pulse; legal range 1-15
CNTW, 16, width of the performance counters (only used with EXP_SEQ_PERF_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start_i  in  1  command request, sampled in IDLE and DONE
cmd_i  in  2  command code: 0=DIFF, 1=INC, 2=DEC, 3=reserved
ack_i  in  1  consumer acknowledges done_o
abort_i  in  1  cancels the operation in progress
overflow_flag_i  in  1  overflow flag from the exponent datapath
underflow_flag_i  in  1  underflow flag from the exponent datapath
ctrl_a_o  out  1  result-register load pulse to the datapath
fsm_add_subt_o  out  1  datapath mode: 0=add, 1=subtract
fsm_select_a_o  out  1  operand-A mux select
fsm_select_b_o  out  1  operand-B mux select
busy_o  out  1  high in every state except IDLE
done_o  out  1  result valid, waiting for ack
ovf_o  out  1  overflow captured for the current result
unf_o  out  1  underflow captured for the current result
err_o  out  1  reserved command was received
op_cnt_o  out  CNTW  completed operations (macro only)
exc_cnt_o  out  CNTW  operations that ended with ovf/unf/err (macro only)

Behaviour:
- rst low (async): state=IDLE; all outputs 0; settle counter 0; counters 0.
- All outputs are registered. States: IDLE, SETUP, LOAD, DONE.
- Command decode, latched on acceptance:
  - DIFF: sel_a=0, sel_b=0, add_subt=1.
  - INC: sel_a=1, sel_b=1, add_subt=0.
  - DEC: sel_a=1, sel_b=1, add_subt=1.
  - Reserved (3): no datapath activity.
- On acceptance: ovf_o, unf_o, err_o are cleared.
- IDLE:
  - start_i with valid cmd -> SETUP; selects and mode are updated on the same edge; settle counter := SETTLE-1.
  - start_i with cmd=3 -> DONE with err_o=1; selects unchanged; no ctrl_a_o pulse.
- SETUP: the counter decrements each cycle; at 0 -> LOAD.
- LOAD:
  - ctrl_a_o=1 for exactly this one cycle.
  - At the end of the cycle, ovf_o <= overflow_flag_i and unf_o <= underflow_flag_i.
  - Next state is DONE.
- DONE:
  - done_o=1 until ack_i.
  - ack_i without start_i -> IDLE.
  - ack_i with start_i -> accept the new command directly (back-to-back), exactly as in IDLE.
  - start_i without ack_i is ignored.
- Latency, SETTLE=1: start accepted at edge T, ctrl_a_o high in cycle T+1, done_o high from T+2. In general, done_o rises SETTLE+1 cycles after acceptance.
- start_i while in SETUP or LOAD is ignored; commands are not queued.
- abort_i in SETUP or LOAD -> IDLE next edge:
  - ctrl_a_o deasserts immediately on that edge.
  - No done_o is produced and flags are not updated.
  - abort_i has priority over the LOAD->DONE transition.
  - abort_i in IDLE or DONE is ignored.
- fsm_select_a_o, fsm_select_b_o and fsm_add_subt_o hold their last values in IDLE and DONE; they change only on acceptance.
- ovf_o, unf_o, err_o remain valid after ack until the next acceptance.

Optional Feature:
EXP_SEQ_PERF_EN:
- Defined: op_cnt_o and exc_cnt_o exist.
  - op_cnt_o increments on each entry to DONE.
  - exc_cnt_o increments on each entry to DONE where ovf, unf or err is set.
  - Both wrap modulo 2^CNTW and are cleared only by reset.
- Not defined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then DIFF with SETTLE=1, flags 0: start at edge T -> sel_a=0, sel_b=0, add_subt=1 after T; ctrl_a_o=1 only in cycle T+1; done_o=1 from T+2; ovf=unf=0.
- INC with overflow_flag_i=1 during LOAD: ovf_o=1, unf_o=0, done_o=1; ack -> IDLE; ovf_o stays 1 until the next start.
- cmd=3: done_o=1 one cycle after start, err_o=1, ctrl_a_o never asserted, selects unchanged.
- SETTLE=4, DEC: ctrl_a_o rises exactly 4 cycles after acceptance; abort_i asserted in the 2nd SETUP cycle -> IDLE, no ctrl_a_o pulse, no done_o.
- Back-to-back: in DONE, ack_i=1 with start_i=1 and cmd=DEC -> next cycle in SETUP with add_subt=1, sel=1/1; done_o low for SETTLE+1 cycles, then high.
- Async reset asserted mid-LOAD: ctrl_a_o, done_o and busy_o drop immediately without waiting for a clock edge. With EXP_SEQ_PERF_EN: after 3 ops, 1 of them overflowing, op_cnt_o=3 and exc_cnt_o=1.
